spi_sample_fifo: RTL and testbench

- Sample buffer on the system clock that feeds the SPI slave's `fifo_rdata` / `fifo_rd` read path.
- System logic pushes 16-bit samples; the SPI side pops them one per `fifo_rd` pulse.
- `fifo_rd` arrives from the SCK domain unsynchronized, so the block synchronizes it and converts it to a single-cycle pop.
- `fifo_rdata` is a registered show-ahead head word, held stable between pops so the SPI shifter can sample it.

---
 rtl/spi_sample_fifo.sv | 103 ++++++++++
 tb/tb_spi_sample_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_sample_fifo.sv
// Show-ahead sample FIFO feeding the SPI slave read path; pops on synchronized fifo_rd rising edges.
// Latency: push to fifo_rdata 1 cycle; fifo_rd rise to pop SYNC_STAGES cycles. Full drops the push (ovf); empty ignores the pop (udf).
// Optional watermark interrupt under FIFO_WMARK_IRQ_EN.
module spi_sample_fifo #(
  parameter int DEPTH       = 16,
  parameter int DW          = 16,
  parameter int AW          = $clog2(DEPTH),
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_sys,
  input  logic          rst_sys,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          clr,
  input  logic          fifo_rd,
  output logic [DW-1:0] fifo_rdata,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          udf,
  input  logic [AW:0]   rg_wmark,
  output logic          wmark_irq
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0]          mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          rd_ptr_next;
  logic [AW:0]            level_next;
  logic [DW-1:0]          head_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   pop;
  logic                   push_acc;
  logic                   pop_acc;

  // fifo_rd is asynchronous; only the synchronized copy is used, and only its rising edge pops.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], fifo_rd};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pop = sync_q[SYNC_STAGES-1] & ~edge_q;

  always_comb begin
    push_acc    = push & (~full | pop);
    pop_acc     = pop & ~empty;
    rd_ptr_next = rd_ptr + AW'(pop_acc);
    level_next  = level + (AW+1)'(push_acc) - (AW+1)'(pop_acc);
    head_next   = '0;
    // The word being written this cycle is not in mem yet, so bypass it when it becomes the head.
    if (level_next != '0) begin
      if (push_acc && (wr_ptr == rd_ptr_next)) head_next = push_data;
      else                                     head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_acc) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys || clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
      fifo_rdata <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push_acc);
      rd_ptr     <= rd_ptr_next;
      level      <= level_next;
      empty      <= (level_next == '0);
      full       <= (level_next == FULL_LVL);
      ovf        <= ovf | (push & full & ~pop);
      udf        <= udf | (pop & empty);
      fifo_rdata <= head_next;
    end
  end

`ifdef FIFO_WMARK_IRQ_EN
  always_ff @(posedge clk_sys) begin
    if (rst_sys || clr) wmark_irq <= 1'b0;
    else                wmark_irq <= (rg_wmark != '0) && (level >= rg_wmark);
  end
`else
  logic unused_rg_wmark;
  assign unused_rg_wmark = ^rg_wmark;
  assign wmark_irq       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sample_fifo.sv
// Directed and randomized bench for spi_sample_fifo against a queue-based reference model.
module tb_spi_sample_fifo;
  localparam int DEPTH = 16;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int S     = 2;

  logic          clk_sys = 1'b0;
  logic          rst_sys;
  logic          push;
  logic [DW-1:0] push_data;
  logic          clr;
  logic          fifo_rd;
  logic [DW-1:0] fifo_rdata;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          udf;
  logic [AW:0]   rg_wmark;
  logic          wmark_irq;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf;
  bit            m_udf;
  bit            m_wm;
  bit            rh[0:7];

  always #5 clk_sys = ~clk_sys;

  spi_sample_fifo #(.DEPTH(DEPTH), .DW(DW), .SYNC_STAGES(S)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .push(push), .push_data(push_data),
    .clr(clr), .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata), .level(level),
    .empty(empty), .full(full), .ovf(ovf), .udf(udf),
    .rg_wmark(rg_wmark), .wmark_irq(wmark_irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a pop is the fifo_rd rising edge seen S edges late; contents are a plain queue.
  task automatic model_edge();
    bit p, pa, wa, wm_n;
    if (rst_sys) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_wm = 0;
      for (int j = 0; j < 8; j++) rh[j] = 0;
    end else begin
      p    = rh[S-1] & ~rh[S];
      wm_n = (rg_wmark != 0) && (q.size() >= int'(rg_wmark));
      for (int j = 7; j > 0; j--) rh[j] = rh[j-1];
      rh[0] = fifo_rd;
      if (clr) begin
        q.delete();
        m_ovf = 0; m_udf = 0; m_wm = 0;
      end else begin
        pa = p && (q.size() > 0);
        wa = push && ((q.size() < DEPTH) || p);
        if (p && q.size() == 0) m_udf = 1;
        if (push && q.size() == DEPTH && !p) m_ovf = 1;
        if (pa) void'(q.pop_front());
        if (wa) q.push_back(push_data);
        m_wm = wm_n;
      end
    end
  endtask

  task automatic compare_all();
    logic [DW-1:0] exp_rd;
    bit            exp_wm;
    exp_rd = (q.size() > 0) ? q[0] : '0;
`ifdef FIFO_WMARK_IRQ_EN
    exp_wm = m_wm;
`else
    exp_wm = 0;
`endif
    chk("rdata", 32'(fifo_rdata), 32'(exp_rd));
    chk("level", 32'(level), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full",  32'(full),  32'(q.size() == DEPTH));
    chk("ovf",   32'(ovf),   32'(m_ovf));
    chk("udf",   32'(udf),   32'(m_udf));
    chk("wmark", 32'(wmark_irq), 32'(exp_wm));
  endtask

  task automatic cyc(input bit ps, input logic [DW-1:0] d, input bit cl, input bit rd);
    push = ps; push_data = d; clr = cl; fifo_rd = rd;
    @(posedge clk_sys);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse_rd(input int hi, input int lo);
    for (int k = 0; k < hi; k++) cyc(0, '0, 0, 1);
    for (int k = 0; k < lo; k++) cyc(0, '0, 0, 0);
  endtask

  initial begin
    bit rd_l;
    bit ps;
    rst_sys = 1; push = 0; push_data = '0; clr = 0; fifo_rd = 0; rg_wmark = 5'd4;
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
    chk("dir_rst_empty", 32'(empty), 32'd1);
    chk("dir_rst_rdata", 32'(fifo_rdata), 32'd0);
    rst_sys = 0;
    cyc(0, '0, 0, 0);

    cyc(1, 16'hA001, 0, 0);
    chk("dir_first_push_rdata", 32'(fifo_rdata), 32'hA001);
    cyc(1, 16'hA002, 0, 0);
    cyc(1, 16'hA003, 0, 0);
    chk("dir_level3", 32'(level), 32'd3);
    chk("dir_not_empty", 32'(empty), 32'd0);

    pulse_rd(10, 3);
    chk("dir_pop1_rdata", 32'(fifo_rdata), 32'hA002);
    chk("dir_pop1_level", 32'(level), 32'd2);
    pulse_rd(4, 3);
    chk("dir_pop2_rdata", 32'(fifo_rdata), 32'hA003);
    chk("dir_pop2_level", 32'(level), 32'd1);
    pulse_rd(3, 2);

    for (int i = 0; i < 16; i++) cyc(1, 16'(i), 0, 0);
    cyc(1, 16'hFFFF, 0, 0);
    chk("dir_full", 32'(full), 32'd1);
    chk("dir_full_level", 32'(level), 32'd16);
    chk("dir_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("dir_drain_order", 32'(fifo_rdata), 32'(i));
      pulse_rd(3, 2);
    end
    chk("dir_drained", 32'(empty), 32'd1);

    for (int i = 0; i < 16; i++) cyc(1, 16'h0100 + 16'(i), 0, 0);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 0, 1);
    cyc(1, 16'h0BEE, 0, 1);
    chk("dir_full_pushpop_level", 32'(level), 32'd16);
    chk("dir_full_pushpop_ovf", 32'(ovf), 32'd1);
    chk("dir_full_pushpop_rdata", 32'(fifo_rdata), 32'h0101);
    pulse_rd(0, 2);
    cyc(0, '0, 1, 0);
    pulse_rd(3, 2);
    chk("dir_udf", 32'(udf), 32'd1);
    chk("dir_udf_level", 32'(level), 32'd0);
    chk("dir_udf_rdata", 32'(fifo_rdata), 32'd0);

    cyc(0, '0, 1, 0);
    cyc(1, 16'hC000, 0, 0);
    cyc(1, 16'hC001, 0, 0);
    for (int i = 2; i < 42; i++) begin
      cyc(1, 16'hC000 + 16'(i), 0, 1);
      pulse_rd(2, 2);
    end
    chk("dir_wrap_head", 32'(fifo_rdata), 32'hC028);
    cyc(1, 16'h1234, 1, 0);
    chk("dir_clr_level", 32'(level), 32'd0);
    chk("dir_clr_empty", 32'(empty), 32'd1);
    chk("dir_clr_rdata", 32'(fifo_rdata), 32'd0);
    chk("dir_clr_flags", 32'({ovf, udf}), 32'd0);

`ifdef FIFO_WMARK_IRQ_EN
    for (int i = 0; i < 4; i++) cyc(1, 16'h5000 + 16'(i), 0, 0);
    chk("dir_wm_at_push", 32'(wmark_irq), 32'd0);
    cyc(0, '0, 0, 0);
    chk("dir_wm_set", 32'(wmark_irq), 32'd1);
    pulse_rd(3, 0);
    chk("dir_wm_pop_edge", 32'(wmark_irq), 32'd1);
    cyc(0, '0, 0, 0);
    chk("dir_wm_clear", 32'(wmark_irq), 32'd0);
    cyc(0, '0, 1, 0);
`else
    for (int i = 0; i < 6; i++) cyc(1, 16'h5000 + 16'(i), 0, 0);
    chk("dir_wm_tied", 32'(wmark_irq), 32'd0);
    cyc(0, '0, 1, 0);
`endif

    rd_l = 0;
    for (int i = 0; i < 600; i++) begin
      ps = ($urandom_range(99) < ((i < 300) ? 75 : 30));
      if ($urandom_range(2) == 0) rd_l = ~rd_l;
      cyc(ps, 16'($urandom), ($urandom_range(63) == 0), rd_l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
